mux8_arb: RTL and testbench
===========================

MUX8_ARB -- requirements
Module: mux8_arb

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per requester; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  request per source; bit i = source i.
REQ-005 d  input  8  data per source; bit i = source i data, routed through the 8:1 select.
REQ-006 gnt  output  8  one-hot grant, registered; all-zero when no grant.
REQ-007 s  output  3  registered mux select, index of current or last granted source.
REQ-008 valid  output  1  registered; high while a grant is active.
REQ-009 y  output  1  selected data: d[s] when valid=1, else 0; combinational from d.

Function
REQ-010 FSM states IDLE and GRANT; reset state IDLE.
REQ-011 Round-robin pointer ptr (3 bits): the search for a new grant starts at index ptr and wraps 7->0.
REQ-012 IDLE: if any req bit is sampled high, the next cycle is GRANT, with gnt/s set to the first requester at or after ptr; else remain IDLE, gnt=0, valid=0, s unchanged.
REQ-013 Grant latency is exactly one cycle from req sampled high in IDLE to gnt/valid high.
REQ-014 GRANT: gnt=one-hot(s), valid=1; the hold counter starts at 0 on grant and increments each GRANT cycle.
REQ-015 Release occurs in the cycle where req[s]=0 is sampled, or where the hold counter equals MAX_HOLD-1, whichever comes first.
REQ-016 On release, ptr is set to s+1 mod 8.
REQ-017 On release, if any req bit is sampled high, a new grant is chosen from the updated ptr and takes effect the next cycle with no idle bubble; else the FSM goes to IDLE.
REQ-018 On timeout with only the current holder requesting, the same source is re-granted and its hold counter restarts at 0.
REQ-019 Requests arriving or dropping for non-holders during GRANT do not affect the current grant.
REQ-020 With MAX_HOLD=1, every grant lasts exactly one cycle and rotation occurs every cycle under full load.
REQ-021 gnt shall never have more than one bit set; s shall always equal the index of the set gnt bit while valid=1.

Reset
REQ-022 rst_n low, at any time including mid-grant: gnt=0, valid=0, s=0, ptr=0, hold counter=0, state IDLE, effective immediately without waiting for clk.
REQ-023 The first arbitration after reset gives source 0 the highest priority.

Configuration
REQ-024 Macro MUX8_ARB_LOCK_EN defined: adds input port lock (1 bit) after req; while lock=1 and req[s]=1 in GRANT, the timeout release is suppressed and the hold counter saturates at MAX_HOLD-1; release on req[s]=0 is unaffected.
REQ-025 Macro MUX8_ARB_LOCK_EN undefined: no lock port; timeout always applies as in REQ-015.

Structure
REQ-026 Package mux8_arb_pkg holds: N_SRC=8, SEL_W=3, the state enum (IDLE, GRANT), and the hold-counter width constant (4 bits).
REQ-027 Sub-module mux8_rr_pick: combinational; inputs req[7:0] and ptr[2:0]; outputs any (1 bit) and idx[2:0], the first set bit at or after ptr with wrap-around.
REQ-028 The 8:1 data selection for y is done inside mux8_arb.

Verification
REQ-029 Reset, then req=8'b0000_0001 -> one cycle later gnt=8'h01, s=0, valid=1; y follows d[0].
REQ-030 MAX_HOLD=4, req=8'hFF held -> grants in order 0,1,2,...,7,0, each lasting 4 cycles, with no gaps.
REQ-031 Holder 3 drops req after 2 cycles while req[5]=1 -> next cycle gnt=8'h20, s=5, with no IDLE cycle.
REQ-032 Only source 6 requesting continuously, MAX_HOLD=4 -> gnt stays 8'h40; the hold counter wraps every 4 cycles; valid stays 1.
REQ-033 rst_n pulled low mid-grant to source 4 -> gnt=0, valid=0, s=0 asynchronously; after release of reset with req=8'h11, source 0 is granted first.
REQ-034 With MUX8_ARB_LOCK_EN defined, lock=1 on holder 2 for 10 cycles while req=8'hFF -> gnt=8'h04 for all 10 cycles; after lock drops, the grant moves to source 3 at the next timeout or release.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the mux8_arb round-robin arbiter/mux.
package mux8_arb_pkg;

    localparam int unsigned N_SRC  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping 7->0.
module mux8_rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic             found;
    logic [SEL_W-1:0] pos;

    always_comb begin
        any   = |req;
        idx   = ptr;
        found = 1'b0;
        pos   = ptr;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            pos = ptr + SEL_W'(k);
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_arb.sv
// Round-robin 8-source arbiter with registered grant and 8:1 data select.
// Optional macro MUX8_ARB_LOCK_EN adds a lock input that suppresses hold timeout.
module mux8_arb
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
`ifdef MUX8_ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [N_SRC-1:0] d,
    output logic [N_SRC-1:0] gnt,
    output logic [SEL_W-1:0] s,
    output logic             valid,
    output logic             y
);

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic [SEL_W-1:0]  s_n;
    logic [N_SRC-1:0]  gnt_n;
    logic              valid_n;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic [SEL_W-1:0]  pick_ptr;
    logic              timeout;
    logic              locked;

    // A single picker serves both cases: from ptr when idle, from s+1 on release.
    assign pick_ptr = (state == GRANT) ? s + SEL_W'(1) : ptr;
    assign timeout  = (hold == HOLD_W'(MAX_HOLD - 1));

`ifdef MUX8_ARB_LOCK_EN
    assign locked = lock & req[s];
`else
    assign locked = 1'b0;
`endif

    mux8_rr_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold;
        s_n     = s;
        gnt_n   = gnt;
        valid_n = valid;
        case (state)
            IDLE: begin
                gnt_n   = '0;
                valid_n = 1'b0;
                if (pick_any) begin
                    state_n = GRANT;
                    s_n     = pick_idx;
                    gnt_n   = onehot(pick_idx);
                    valid_n = 1'b1;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (!req[s] || (timeout && !locked)) begin
                    ptr_n = pick_ptr;
                    if (pick_any) begin
                        s_n     = pick_idx;
                        gnt_n   = onehot(pick_idx);
                        valid_n = 1'b1;
                        hold_n  = '0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        valid_n = 1'b0;
                        hold_n  = '0;
                    end
                end else begin
                    // Under lock the counter sits at its last value until release.
                    hold_n = timeout ? hold : hold + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            hold  <= '0;
            s     <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hold  <= hold_n;
            s     <= s_n;
            gnt   <= gnt_n;
            valid <= valid_n;
        end
    end

    always_comb begin
        y = 1'b0;
        if (valid) y = d[s];
    end

endmodule

// File: tb/tb_mux8_arb.sv
// Scoreboard bench for mux8_arb: reference model pushes expectations, monitor pops and compares.
module tb_mux8_arb;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d;
    logic       lock;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       valid;
    logic       y;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] s;
        logic       valid;
    } exp_t;

    exp_t q[$];

    // Reference model state: current holder, cycles already held, search start.
    bit m_busy;
    int m_cur;
    int m_held;
    int m_ptr;

    always #5 clk = ~clk;

    mux8_arb #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
`ifdef MUX8_ARB_LOCK_EN
        .lock  (lock),
`endif
        .d     (d),
        .gnt   (gnt),
        .s     (s),
        .valid (valid),
        .y     (y)
    );

    function automatic int first_from(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return p;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_cur = 0; m_held = 0; m_ptr = 0;
    endtask

    task automatic model_step(logic [7:0] r, logic lk);
        bit rel;
        if (!m_busy) begin
            if (r != 0) begin
                m_cur = first_from(r, m_ptr); m_busy = 1; m_held = 0;
            end
        end else begin
`ifdef MUX8_ARB_LOCK_EN
            rel = !r[m_cur] || (m_held >= MH - 1 && !(lk && r[m_cur]));
`else
            rel = !r[m_cur] || (m_held >= MH - 1);
            if (lk) rel = rel;
`endif
            if (rel) begin
                m_ptr = (m_cur + 1) % 8;
                if (r != 0) begin
                    m_cur = first_from(r, m_ptr); m_held = 0;
                end else begin
                    m_busy = 0; m_held = 0;
                end
            end else if (m_held < MH - 1) begin
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle(logic [7:0] r, logic [7:0] dv, logic lk);
        exp_t e;
        @(posedge clk);
        if (rst_n) begin
            model_step(req, lock);
            e.gnt   = m_busy ? (8'd1 << m_cur) : 8'd0;
            e.s     = 3'(m_cur);
            e.valid = m_busy;
            q.push_back(e);
        end
        #1;
        req = r; d = dv; lock = lk;
    endtask

    // Monitor: compares DUT outputs with the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        logic ey;
        if (rst_n && q.size() > 0) begin
            e  = q.pop_front();
            ey = e.valid ? d[e.s] : 1'b0;
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("valid", 32'(valid), 32'(e.valid));
            check("s", 32'(s), 32'(e.s));
            check("y", 32'(y), 32'(ey));
        end
    end

    initial begin
        int n;
        logic [7:0] rr;
        rst_n = 1'b0; req = '0; d = '0; lock = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requester 0, data toggling
        cycle(8'h01, 8'h01, 0);
        for (int i = 0; i < 4; i++) cycle(8'h01, 8'(i * 37), 0);
        cycle(8'h00, 8'h00, 0);
        cycle(8'h00, 8'hFF, 0);

        // Full load rotation
        for (int i = 0; i < 40; i++) cycle(8'hFF, 8'($urandom), 0);
        cycle(8'h00, 8'h00, 0);
        cycle(8'h00, 8'h00, 0);

        // Holder 3 drops early while 5 waits
        cycle(8'h08, 8'h08, 0);
        cycle(8'h28, 8'h28, 0);
        cycle(8'h28, 8'h20, 0);
        cycle(8'h20, 8'h20, 0);
        cycle(8'h20, 8'h00, 0);
        cycle(8'h00, 8'h00, 0);
        cycle(8'h00, 8'h00, 0);

        // Lone source 6 re-granted across timeouts
        for (int i = 0; i < 14; i++) cycle(8'h40, 8'($urandom), 0);
        cycle(8'h00, 8'h00, 0);
        cycle(8'h00, 8'h00, 0);

        // Asynchronous reset in the middle of a grant to source 4
        for (int i = 0; i < 3; i++) cycle(8'h10, 8'h10, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_s", 32'(s), 32'h0);
        check("rst_y", 32'(y), 32'h0);
        q.delete();
        model_reset();
        req = 8'h11;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle(8'h11, 8'($urandom), 0);

`ifdef MUX8_ARB_LOCK_EN
        cycle(8'h00, 8'h00, 0);
        cycle(8'h00, 8'h00, 0);
        n = 0;
        cycle(8'hFF, 8'hFF, 0);
        while (!(m_busy && m_cur == 2) && n < 40) begin
            cycle(8'hFF, 8'hFF, 0);
            n++;
        end
        check("lock_reach2", 32'(m_cur), 32'd2);
        for (int i = 0; i < 10; i++) cycle(8'hFF, 8'($urandom), 1);
        for (int i = 0; i < 8; i++) cycle(8'hFF, 8'($urandom), 0);
`endif

        // Randomized traffic with sticky requests
        rr = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 8'($urandom);
            cycle(rr, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        cycle(8'h00, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
